// File: rtl/qpsk_demodulator_if.sv
// qpsk_demodulator_if -- sample input and demodulated output bundle of the QPSK demodulator.
// The master side (stimulus source / downstream) drives the samples; the slave side is the demodulator.
interface qpsk_demodulator_if #(
   parameter int ACC_W = 32
) ();
   logic                    enable;
   logic                    phase_sync;
   logic signed [15:0]      wave_in;
   logic signed [ACC_W-1:0] I_acc_out;
   logic signed [ACC_W-1:0] Q_acc_out;
   logic [1:0]              sym_pair;
   logic                    sym_valid;
   logic                    bit_out;
   logic                    bit_valid;
   logic                    sat_flag;

   modport master (
      output enable, phase_sync, wave_in,
      input  I_acc_out, Q_acc_out, sym_pair, sym_valid, bit_out, bit_valid, sat_flag
   );

   modport slave (
      input  enable, phase_sync, wave_in,
      output I_acc_out, Q_acc_out, sym_pair, sym_valid, bit_out, bit_valid, sat_flag
   );
endinterface

// File: rtl/qpsk_demodulator.sv
// qpsk_demodulator -- QPSK receive path: mixes each carrier sample down with a 16-entry
// cos/sin table, integrates-and-dumps over SYM_LEN samples, slices the I/Q integrals to a
// bit pair and serialises the pair (older bit first).
// Optional macro QPSK_DEMOD_SAT_EN: accumulators saturate and a sticky sat_flag reports any
// clamp; without it the accumulators wrap and sat_flag is tied low.
module qpsk_demodulator #(
   parameter int SYM_LEN = 16,
   parameter int ACC_W   = 32
) (
   input logic               clk,
   input logic               rst_n,
   qpsk_demodulator_if.slave bus
);
   localparam int PROD_W = 24;
   localparam int SAMP_W = $clog2(SYM_LEN);
   localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
   localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SYM_LEN - 1);

   // Carrier cosine table, amplitude 127, 16 phases per carrier period.
   function automatic logic signed [7:0] cos_lut(input logic [3:0] ph);
      case (ph)
         4'd0:    cos_lut = 8'sd127;
         4'd1:    cos_lut = 8'sd118;
         4'd2:    cos_lut = 8'sd90;
         4'd3:    cos_lut = 8'sd49;
         4'd5:    cos_lut = -8'sd49;
         4'd6:    cos_lut = -8'sd90;
         4'd7:    cos_lut = -8'sd118;
         4'd8:    cos_lut = -8'sd127;
         4'd9:    cos_lut = -8'sd118;
         4'd10:   cos_lut = -8'sd90;
         4'd11:   cos_lut = -8'sd49;
         4'd13:   cos_lut = 8'sd49;
         4'd14:   cos_lut = 8'sd90;
         4'd15:   cos_lut = 8'sd118;
         default: cos_lut = 8'sd0;
      endcase
   endfunction

   // Accumulator add; returns {clamped, result}. Overflow is detected on a widened sum so the
   // product may be wider than the accumulator.
   function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                              input logic [PROD_W-1:0] prod);
      logic [SUM_W-1:0]       sum;
      logic [SUM_W-ACC_W:0]   top;
      logic                   in_range;
      sum = {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc} + {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod};
      top = sum[SUM_W-1:ACC_W-1];
      in_range = (&top) | (~|top);
`ifdef QPSK_DEMOD_SAT_EN
      if (in_range) begin
         acc_add = {1'b0, sum[ACC_W-1:0]};
      end else if (sum[SUM_W-1]) begin
         acc_add = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      end else begin
         acc_add = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
      end
`else
      acc_add = {~in_range, sum[ACC_W-1:0]};
`endif
   endfunction

   logic [3:0]              phase_q, phase_d;
   logic [SAMP_W-1:0]       samp_q, samp_d;
   logic signed [PROD_W-1:0] p_i_q, p_i_d, p_q_q, p_q_d;
   logic                    p_valid_q, p_valid_d, p_last_q, p_last_d;
   logic [ACC_W-1:0]        acc_i_q, acc_i_d, acc_q_q, acc_q_d;
   logic [ACC_W-1:0]        i_out_q, i_out_d, q_out_q, q_out_d;
   logic [1:0]              pair_q, pair_d;
   logic                    sym_valid_q, sym_valid_d;
   logic                    bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
   logic                    pend_bit_q, pend_bit_d, pend_valid_q, pend_valid_d;
   logic                    sat_q, sat_d;

   logic signed [7:0]       cos_s, sin_s;
   logic signed [PROD_W-1:0] prod_i_s, prod_q_s;
   logic                    samp_last_s;
   logic [ACC_W:0]          add_i_s, add_q_s;

   // Mixer: table lookup (sin is cos delayed by a quarter period) and the two products.
   always_comb begin
      cos_s       = cos_lut(phase_q);
      sin_s       = cos_lut(phase_q - 4'd4);
      prod_i_s    = bus.wave_in * cos_s;
      prod_q_s    = -(bus.wave_in * sin_s);
      samp_last_s = (samp_q == SAMP_LAST);
      add_i_s     = acc_add(acc_i_q, p_i_q);
      add_q_s     = acc_add(acc_q_q, p_q_q);
   end

   // Counters, product stage and integrate-and-dump; phase_sync restarts the symbol.
   always_comb begin
      phase_d     = phase_q;
      samp_d      = samp_q;
      p_i_d       = '0;
      p_q_d       = '0;
      p_valid_d   = 1'b0;
      p_last_d    = 1'b0;
      acc_i_d     = acc_i_q;
      acc_q_d     = acc_q_q;
      i_out_d     = i_out_q;
      q_out_d     = q_out_q;
      pair_d      = pair_q;
      sym_valid_d = 1'b0;
      sat_d       = sat_q;
      if (bus.phase_sync) begin
         phase_d = 4'd0;
         samp_d  = '0;
         acc_i_d = '0;
         acc_q_d = '0;
      end else begin
         if (bus.enable) begin
            phase_d   = phase_q + 4'd1;
            samp_d    = samp_last_s ? '0 : samp_q + SAMP_W'(1);
            p_i_d     = prod_i_s;
            p_q_d     = prod_q_s;
            p_valid_d = 1'b1;
            p_last_d  = samp_last_s;
         end else begin
            phase_d = phase_q;
            samp_d  = samp_q;
         end
         if (p_valid_q) begin
`ifdef QPSK_DEMOD_SAT_EN
            sat_d = sat_q | add_i_s[ACC_W] | add_q_s[ACC_W];
`else
            sat_d = 1'b0;
`endif
            if (p_last_q) begin
               // A sum of exactly zero slices as positive (sign bit 0).
               i_out_d     = add_i_s[ACC_W-1:0];
               q_out_d     = add_q_s[ACC_W-1:0];
               pair_d      = {add_q_s[ACC_W-1], add_i_s[ACC_W-1]};
               sym_valid_d = 1'b1;
               acc_i_d     = '0;
               acc_q_d     = '0;
            end else begin
               acc_i_d = add_i_s[ACC_W-1:0];
               acc_q_d = add_q_s[ACC_W-1:0];
            end
         end else begin
            acc_i_d = acc_i_q;
            acc_q_d = acc_q_q;
         end
      end
   end

   // Serializer: emits the older bit on the cycle after sym_valid, the newer bit one later.
   always_comb begin
      bit_out_d    = bit_out_q;
      bit_valid_d  = 1'b0;
      pend_bit_d   = pend_bit_q;
      pend_valid_d = 1'b0;
      if (sym_valid_q) begin
         bit_out_d    = pair_q[1];
         bit_valid_d  = 1'b1;
         pend_bit_d   = pair_q[0];
         pend_valid_d = 1'b1;
      end else if (pend_valid_q) begin
         bit_out_d   = pend_bit_q;
         bit_valid_d = 1'b1;
      end else begin
         bit_out_d = bit_out_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_q      <= 4'd0;
         samp_q       <= '0;
         p_i_q        <= '0;
         p_q_q        <= '0;
         p_valid_q    <= 1'b0;
         p_last_q     <= 1'b0;
         acc_i_q      <= '0;
         acc_q_q      <= '0;
         i_out_q      <= '0;
         q_out_q      <= '0;
         pair_q       <= 2'b00;
         sym_valid_q  <= 1'b0;
         bit_out_q    <= 1'b0;
         bit_valid_q  <= 1'b0;
         pend_bit_q   <= 1'b0;
         pend_valid_q <= 1'b0;
         sat_q        <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         samp_q       <= samp_d;
         p_i_q        <= p_i_d;
         p_q_q        <= p_q_d;
         p_valid_q    <= p_valid_d;
         p_last_q     <= p_last_d;
         acc_i_q      <= acc_i_d;
         acc_q_q      <= acc_q_d;
         i_out_q      <= i_out_d;
         q_out_q      <= q_out_d;
         pair_q       <= pair_d;
         sym_valid_q  <= sym_valid_d;
         bit_out_q    <= bit_out_d;
         bit_valid_q  <= bit_valid_d;
         pend_bit_q   <= pend_bit_d;
         pend_valid_q <= pend_valid_d;
         sat_q        <= sat_d;
      end
   end

   assign bus.I_acc_out = i_out_q;
   assign bus.Q_acc_out = q_out_q;
   assign bus.sym_pair  = pair_q;
   assign bus.sym_valid = sym_valid_q;
   assign bus.bit_out   = bit_out_q;
   assign bus.bit_valid = bit_valid_q;
   assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_qpsk_demodulator.sv
// tb_qpsk_demodulator -- scoreboard bench for qpsk_demodulator. Two instances (32-bit and
// 20-bit integrators) see the same samples; a symbol-level reference model pushes expected
// symbols and bits, and monitors pop and compare whenever the DUTs strobe.
module tb_qpsk_demodulator;
   localparam int SYM_LEN = 16;
   localparam int AW_A    = 32;
   localparam int AW_B    = 20;
`ifdef QPSK_DEMOD_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct packed {
      logic signed [63:0] i;
      logic signed [63:0] q;
      logic [1:0]         pair;
      logic               sat;
   } sym_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   // Cycle counter used for latency measurements.
   always @(posedge clk) cyc <= cyc + 1;

   qpsk_demodulator_if #(.ACC_W(AW_A)) bus_a ();
   qpsk_demodulator_if #(.ACC_W(AW_B)) bus_b ();

   qpsk_demodulator #(.SYM_LEN(SYM_LEN), .ACC_W(AW_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   qpsk_demodulator #(.SYM_LEN(SYM_LEN), .ACC_W(AW_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   int cos_t [16] = '{127, 118, 90, 49, 0, -49, -90, -118, -127, -118, -90, -49, 0, 49, 90, 118};

   sym_t exp_sym_a[$];
   sym_t exp_sym_b[$];
   bit   exp_bit_a[$];
   bit   exp_bit_b[$];

   int     m_phase, m_samp;
   longint m_ai, m_aq, m_bi, m_bq;
   bit     m_sat_a, m_sat_b, m_sat_a_prev, m_sat_b_prev, m_just_done;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int sin_of(input int k);
      return cos_t[(k + 12) % 16];
   endfunction

   // Bring a mathematical sum into a w-bit signed integrator (clamp or wrap).
   function automatic longint fit(input longint v, input int w, inout bit flag);
      longint hi, lo, m;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      m  = 64'sd1 <<< w;
      if (SAT) begin
         if (v > hi) begin flag = 1'b1; return hi; end
         if (v < lo) begin flag = 1'b1; return lo; end
         return v;
      end
      v = v & (m - 64'sd1);
      if (v > hi) v = v - m;
      return v;
   endfunction

   task automatic model_clear();
      m_phase = 0; m_samp = 0;
      m_ai = 0; m_aq = 0; m_bi = 0; m_bq = 0;
      m_sat_a = 1'b0; m_sat_b = 1'b0; m_sat_a_prev = 1'b0; m_sat_b_prev = 1'b0;
      m_just_done = 1'b0;
   endtask

   task automatic push_sym();
      sym_t e;
      e.i = m_ai; e.q = m_aq; e.pair = {m_aq < 0, m_ai < 0}; e.sat = m_sat_a;
      exp_sym_a.push_back(e);
      exp_bit_a.push_back(e.pair[1]); exp_bit_a.push_back(e.pair[0]);
      e.i = m_bi; e.q = m_bq; e.pair = {m_bq < 0, m_bi < 0}; e.sat = m_sat_b;
      exp_sym_b.push_back(e);
      exp_bit_b.push_back(e.pair[1]); exp_bit_b.push_back(e.pair[0]);
   endtask

   // Reference: one call per cycle with the inputs the DUTs will sample at the next edge.
   task automatic model(input bit en, input bit sync, input int w);
      longint pi, pq;
      if (sync) begin
         if (m_just_done) begin
            // The completing product is still in flight and is lost with the sync.
            exp_sym_a.delete(exp_sym_a.size() - 1);
            exp_sym_b.delete(exp_sym_b.size() - 1);
            repeat (2) begin
               exp_bit_a.delete(exp_bit_a.size() - 1);
               exp_bit_b.delete(exp_bit_b.size() - 1);
            end
            m_sat_a = m_sat_a_prev;
            m_sat_b = m_sat_b_prev;
         end
         m_phase = 0; m_samp = 0;
         m_ai = 0; m_aq = 0; m_bi = 0; m_bq = 0;
         m_just_done = 1'b0;
      end else if (en) begin
         pi = longint'(w) * cos_t[m_phase];
         pq = -(longint'(w) * sin_of(m_phase));
         m_sat_a_prev = m_sat_a;
         m_sat_b_prev = m_sat_b;
         m_ai = fit(m_ai + pi, AW_A, m_sat_a);
         m_aq = fit(m_aq + pq, AW_A, m_sat_a);
         m_bi = fit(m_bi + pi, AW_B, m_sat_b);
         m_bq = fit(m_bq + pq, AW_B, m_sat_b);
         m_phase = (m_phase + 1) % 16;
         m_samp++;
         m_just_done = (m_samp == SYM_LEN);
         if (m_just_done) begin
            push_sym();
            m_samp = 0;
            m_ai = 0; m_aq = 0; m_bi = 0; m_bq = 0;
         end
      end else begin
         m_just_done = 1'b0;
      end
   endtask

   task automatic set_inputs(input bit en, input bit sync, input int w);
      bus_a.enable = en; bus_a.phase_sync = sync; bus_a.wave_in = 16'(w);
      bus_b.enable = en; bus_b.phase_sync = sync; bus_b.wave_in = 16'(w);
   endtask

   task automatic drive(input bit en, input bit sync, input int w);
      @(posedge clk);
      #1;
      set_inputs(en, sync, w);
      model(en, sync, w);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      set_inputs(1'b0, 1'b0, 0);
      repeat (n - 1) @(posedge clk);
      @(negedge clk);
      chk("rst A I_acc_out", bus_a.I_acc_out, 0);
      chk("rst A Q_acc_out", bus_a.Q_acc_out, 0);
      chk("rst A sym_pair",  bus_a.sym_pair, 0);
      chk("rst A sym_valid", bus_a.sym_valid, 0);
      chk("rst A bit_out",   bus_a.bit_out, 0);
      chk("rst A bit_valid", bus_a.bit_valid, 0);
      chk("rst A sat_flag",  bus_a.sat_flag, 0);
      chk("rst B I_acc_out", bus_b.I_acc_out, 0);
      chk("rst B Q_acc_out", bus_b.Q_acc_out, 0);
      chk("rst B sat_flag",  bus_b.sat_flag, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_clear();
      exp_sym_a.delete(); exp_sym_b.delete();
      exp_bit_a.delete(); exp_bit_b.delete();
   endtask

   function automatic int wave_for(input int kind, input int k);
      if (kind == 0) return cos_t[k];
      if (kind == 1) return sin_of(k);
      return (cos_t[k] >= 0) ? 32767 : -32768;
   endfunction

   // kind: 0 cos, 1 sin, 2 full-scale; step 2 inserts an idle cycle after every sample.
   task automatic send_sym(input int kind, input int step, output int c0);
      c0 = -1;
      for (int k = 0; k < SYM_LEN; k++) begin
         drive(1'b1, 1'b0, wave_for(kind, k % 16));
         if (k == 0) c0 = cyc;
         if (step == 2) drive(1'b0, 1'b0, 0);
      end
   endtask

   task automatic wait_sym(output int at_cyc);
      at_cyc = -1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (bus_a.sym_valid === 1'b1) begin
            at_cyc = cyc;
            break;
         end
      end
      if (at_cyc < 0) chk("sym_valid timeout", bus_a.sym_valid, 1);
   endtask

   sym_t mon_a, mon_b;

   // Monitor for the 32-bit instance: pop and compare on every strobe.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_a.sym_valid) begin
            if (exp_sym_a.size() == 0) begin
               chk("A unexpected sym_valid", bus_a.sym_valid, 0);
            end else begin
               mon_a = exp_sym_a.pop_front();
               chk("A I_acc_out", bus_a.I_acc_out, mon_a.i);
               chk("A Q_acc_out", bus_a.Q_acc_out, mon_a.q);
               chk("A sym_pair",  bus_a.sym_pair, mon_a.pair);
               chk("A sat_flag",  bus_a.sat_flag, mon_a.sat);
            end
         end
         if (bus_a.bit_valid) begin
            if (exp_bit_a.size() == 0) chk("A unexpected bit_valid", bus_a.bit_valid, 0);
            else chk("A bit_out", bus_a.bit_out, exp_bit_a.pop_front());
         end
      end
   end

   // Monitor for the 20-bit instance.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_b.sym_valid) begin
            if (exp_sym_b.size() == 0) begin
               chk("B unexpected sym_valid", bus_b.sym_valid, 0);
            end else begin
               mon_b = exp_sym_b.pop_front();
               chk("B I_acc_out", bus_b.I_acc_out, mon_b.i);
               chk("B Q_acc_out", bus_b.Q_acc_out, mon_b.q);
               chk("B sym_pair",  bus_b.sym_pair, mon_b.pair);
               chk("B sat_flag",  bus_b.sat_flag, mon_b.sat);
            end
         end
         if (bus_b.bit_valid) begin
            if (exp_bit_b.size() == 0) chk("B unexpected bit_valid", bus_b.bit_valid, 0);
            else chk("B bit_out", bus_b.bit_out, exp_bit_b.pop_front());
         end
      end
   end

   // Absolute time limit.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int     c0, t;
      longint total, exp_i;
      model_clear();
      set_inputs(1'b0, 1'b0, 0);
      do_reset(2);

      // Cosine input: pure I, zero Q.
      send_sym(0, 1, c0);
      idle(1);
      wait_sym(t);
      chk("T2 latency", t - c0, SYM_LEN + 1);
      chk("T2 I_acc_out", bus_a.I_acc_out, 129958);
      chk("T2 Q_acc_out", bus_a.Q_acc_out, 0);
      chk("T2 sym_pair",  bus_a.sym_pair, 0);
      idle(4);

      // Sine input: pure negative Q.
      send_sym(1, 1, c0);
      idle(1);
      wait_sym(t);
      chk("T3 I_acc_out", bus_a.I_acc_out, 0);
      chk("T3 Q_acc_out", bus_a.Q_acc_out, -129958);
      chk("T3 sym_pair",  bus_a.sym_pair, 2);
      idle(4);

      // Reset in the middle of a symbol, then a full symbol.
      for (int k = 0; k < 7; k++) drive(1'b1, 1'b0, cos_t[k]);
      do_reset(2);
      send_sym(0, 1, c0);
      idle(1);
      wait_sym(t);
      chk("T1 latency", t - c0, SYM_LEN + 1);
      chk("T1 I_acc_out", bus_a.I_acc_out, 129958);
      idle(4);

      // Enable toggling every cycle.
      send_sym(0, 2, c0);
      wait_sym(t);
      chk("T4 latency", t - c0, 2 * SYM_LEN);
      chk("T4 I_acc_out", bus_a.I_acc_out, 129958);
      chk("T4 Q_acc_out", bus_a.Q_acc_out, 0);
      idle(4);

      // phase_sync at sample 7 drops the partial symbol.
      for (int k = 0; k < 7; k++) drive(1'b1, 1'b0, cos_t[k]);
      drive(1'b1, 1'b1, cos_t[7]);
      send_sym(0, 1, c0);
      idle(1);
      wait_sym(t);
      chk("T5 latency", t - c0, SYM_LEN + 1);
      chk("T5 I_acc_out", bus_a.I_acc_out, 129958);
      idle(4);

      // Full-scale input into the 20-bit integrator.
      total = 0;
      for (int k = 0; k < SYM_LEN; k++) total += longint'(wave_for(2, k % 16)) * cos_t[k % 16];
      exp_i = ((total & 64'sh0FFFFF) ^ 64'sh080000) - 64'sh080000;
      if (SAT) exp_i = 524287;
      send_sym(2, 1, c0);
      idle(1);
      wait_sym(t);
      chk("T6 B I_acc_out", bus_b.I_acc_out, exp_i);
      chk("T6 B sat_flag", bus_b.sat_flag, SAT);
      idle(8);
      chk("T6 B sat_flag held", bus_b.sat_flag, SAT);

      // Randomized traffic.
      for (int n = 0; n < 1500; n++) begin
         drive(($urandom % 4) != 0, ($urandom % 50) == 0, int'($urandom_range(0, 65535)) - 32768);
      end
      idle(8);
      chk("A symbols left", exp_sym_a.size(), 0);
      chk("A bits left",    exp_bit_a.size(), 0);
      chk("B symbols left", exp_sym_b.size(), 0);
      chk("B bits left",    exp_bit_b.size(), 0);
      chk("B final sat_flag", bus_b.sat_flag, m_sat_b);
      chk("A final sat_flag", bus_a.sat_flag, m_sat_a);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
